mips32_mem_responder: RTL and testbench

MIPS32_MEM_RESPONDER -- requirements
Module: mips32_mem_responder

---
 rtl/mips32_mem_responder.sv | 143 ++++++++++++++
 tb/tb_mips32_mem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_responder.sv
// Word-addressed memory responder with a valid/ready request and response handshake and fixed wait states.
// Optional macro MEM_RESP_RANGE_CHECK_EN: out-of-range addresses return an error instead of wrapping.
module mips32_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH       = 1024
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH];

  logic            access_c;
  logic            direct_c;
  logic            acc_we_c;
  logic [31:0]     acc_addr_c;
  logic [31:0]     acc_wdata_c;
  logic [AW-1:0]   acc_idx_c;
  logic            in_range_c;
  logic            mem_we_c;

  // A zero-wait access happens on the acceptance edge, so it uses the live request fields.
  assign direct_c    = (state_q == ST_IDLE);
  assign acc_we_c    = direct_c ? req_we    : we_q;
  assign acc_addr_c  = direct_c ? req_addr  : addr_q;
  assign acc_wdata_c = direct_c ? req_wdata : wdata_q;
  assign acc_idx_c   = acc_addr_c[AW-1:0];

`ifdef MEM_RESP_RANGE_CHECK_EN
  assign in_range_c = (acc_addr_c < 32'(DEPTH));
`else
  logic unused_addr_hi;
  assign in_range_c     = 1'b1;
  assign unused_addr_hi = ^acc_addr_c[31:AW];
`endif

  assign mem_we_c = access_c & acc_we_c & in_range_c;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset so contents survive rst_n.
  always_ff @(posedge clk1) begin
    if (mem_we_c) begin
      mem[acc_idx_c] <= acc_wdata_c;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    access_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CW'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            access_c = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CW'(1)) begin
          access_c = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RESP;
        end else begin
          cnt_d    = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (access_c) begin
      rdata_d = (acc_we_c || !in_range_c) ? 32'h0 : mem[acc_idx_c];
      err_d   = !in_range_c;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Randomized bench for mips32_mem_responder against an array-based reference model with fixed-latency expectations.
module tb_mips32_mem_responder;

  localparam int unsigned WAIT_CYCLES = 2;
  localparam int unsigned DEPTH       = 1024;

  logic        clk1;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [DEPTH];

  mips32_mem_responder #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .DEPTH      (DEPTH)
  ) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic out_of_range(input logic [31:0] a);
`ifdef MEM_RESP_RANGE_CHECK_EN
    return (a >= 32'(DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_ready();
    int i = 0;
    while (!req_ready && i < 20) begin
      step();
      i++;
    end
    check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // One complete transaction: issue, check latency and response, hold, handshake.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int hold, input string tag);
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat;
    exp_e = out_of_range(addr);
    exp_d = (we || exp_e) ? 32'h0 : model[addr % DEPTH];
    wait_ready();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (we && !exp_e) model[addr % DEPTH] = wdata;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(WAIT_CYCLES));
    check({tag, "_rdata"}, rsp_rdata, exp_d);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, exp_d);
      check({tag, "_hold_busy"}, 32'(busy), 32'd1);
      check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          acc;
    int          acc_cyc [8];
    logic [31:0] a;
    logic [31:0] old7;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;

    repeat (2) step();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 48; i++) xfer(1'b1, 32'(i), $urandom, 0, "pre");

    xfer(1'b1, 32'd5, 32'hDEADBEEF, 0, "st5");
    xfer(1'b0, 32'd5, 32'h0, 0, "ld5");

    xfer(1'b0, 32'd9, 32'h0, 4, "ld9_hold");

    xfer(1'b1, 32'd1030, 32'h12345678, 0, "st1030");
    xfer(1'b0, 32'd6, 32'h0, 0, "ld6");

    // Reset while a store is waiting: the store must not land.
    old7 = 32'h0BADF00D;
    xfer(1'b1, 32'd7, old7, 0, "st7_old");
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd7;
    req_wdata = 32'hAAAA0000;
    step();
    req_valid = 1'b0;
    step();
    check("wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wrst_busy", 32'(busy), 32'd0);
    check("wrst_req_ready", 32'(req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    xfer(1'b0, 32'd7, 32'h0, 0, "ld7");

    // Reset while a response is pending drops it.
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'd3;
    step();
    req_valid = 1'b0;
    repeat (WAIT_CYCLES) step();
    check("resp_pending", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rrst_rsp_rdata", rsp_rdata, 32'd0);
    check("rrst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;

    // Back-to-back stores with req_valid held; fields while not ready are garbage.
    wait_ready();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 16; c++) begin
      if (rsp_valid) check("b2b_rdata", rsp_rdata, 32'd0);
      if (req_ready) begin
        req_we    = 1'b1;
        req_addr  = 32'(40 + acc);
        req_wdata = $urandom;
        model[40 + acc] = req_wdata;
        acc_cyc[acc] = c;
        acc++;
      end else begin
        req_we    = 1'($urandom);
        req_addr  = 32'(40 + ((acc > 0) ? acc - 1 : 0));
        req_wdata = $urandom;
      end
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_count", 32'(acc), 32'd4);
    for (int i = 0; i + 1 < acc; i++) check("b2b_gap", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd4);
    for (int i = 0; i < acc; i++) xfer(1'b0, 32'(40 + i), 32'h0, 0, "b2b_ld");

    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 47));
      if ($urandom_range(0, 4) == 0) a = a + 32'(DEPTH) * 32'($urandom_range(1, 3));
      xfer(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
